dcache_wb_ctrl: RTL and testbench
=================================

Name: dcache_wb_ctrl

Overview:
Parametrised direct-mapped, write-back, write-allocate data cache with its own miss-handling FSM. It replaces the single-cycle cache/main-memory pairing with a handshaked backing-memory port of arbitrary latency. It sits between the core's memory stage and data memory. It raises `stall` while a miss is serviced and returns read data combinationally on a hit.

Parameters:
DATA_WIDTH, 32, CPU word and memory word width; fixed at 32 for RV32I.
SETS, 8, number of lines; power of 2, minimum 2.
WORDS_PER_BLOCK, 4, words per line; power of 2, minimum 1.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data; a byte store uses bits [7:0]
cpu_byte  in  1  1 = byte access, 0 = word access
cpu_wen  in  1  store request
cpu_ren  in  1  load request
cpu_rdata  out  32  load data; a byte load is zero-extended
stall  out  1  core must hold its request stable while this is high
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write transaction, 0 = read transaction
mem_addr  out  32  word-aligned memory address
mem_wdata  out  32  write-back data
mem_rdata  in  32  refill data, valid in the cycle `mem_ack` is high
mem_ack  in  1  one-cycle completion pulse for the current transaction

Behaviour:
- Address split:
  - offset = [1:0]
  - word = next log2(WORDS_PER_BLOCK) bits
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Per-line storage: valid bit, dirty bit, tag, WORDS_PER_BLOCK data words.
- Request and hit:
  - req = cpu_ren | cpu_wen.
  - cpu_wen=1 with cpu_ren=1 is treated as a store.
  - hit = valid[index] & (tag[index] == addr tag).
- Hit timing:
  - stall = req & ~hit & ~rst, driven combinationally in IDLE.
  - stall is 1 in every non-IDLE state.
- Load hit:
  - cpu_rdata is combinational with zero added cycles.
  - Byte lane is selected by offset.
  - When not a load hit, cpu_rdata = 0.
- Store hit:
  - Written at the clock edge; dirty is set.
  - A byte store writes only lane `offset`.
  - A word store with offset != 0 is treated as word-aligned (offset ignored).
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
  - IDLE -> WRITEBACK on req & ~hit & valid & dirty.
  - IDLE -> REFILL on req & ~hit & ~(valid & dirty).
  - WRITEBACK:
    - Issues WORDS_PER_BLOCK write transactions to {old tag, index, word=k, 2'b00} for k = 0..N-1 in order.
    - -> REFILL after the last `mem_ack`.
  - REFILL:
    - Issues N read transactions to {new tag, index, k, 2'b00} in order.
    - Each `mem_ack` writes mem_rdata into word k.
    - On the last `mem_ack`: tag is updated, valid=1, dirty=0, -> DONE.
  - DONE: one cycle, then -> IDLE. The retried request then hits; stall drops in that cycle.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They are held stable from assertion until the cycle `mem_ack`=1.
  - mem_req is deasserted for at least one cycle between transactions.
  - `mem_ack` while mem_req=0 is ignored.
- Word counter:
  - Width log2(WORDS_PER_BLOCK), minimum 1 bit.
  - Cleared on entry to WRITEBACK and to REFILL.
  - Wraps to 0 after the last word.
- Miss latency: with a memory acking 1 cycle after request, stall lasts 2N+2 cycles for a clean miss and 4N+2 cycles for a dirty miss.
- Reset:
  - All valid and dirty bits are cleared; state = IDLE; counter = 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rdata=0 and stall=0 while rst=1.
  - Data and tag arrays are not cleared.
- Reset mid-miss: the transaction is abandoned and the partially refilled line stays invalid. A dirty line mid-writeback is lost; this is accepted.
- No request (ren=wen=0): no state change, stall=0.

Test Plan:
- Reset, then load word 0x0000_0100 → stall high for 10 cycles with 1-cycle memory ack, and 4 read transactions at 0x100, 0x104, 0x108, 0x10C. After refill, cpu_rdata equals memory[0x100] with stall=0.
- After that refill, load byte 0x0000_0106 → same-cycle hit, no mem_req; cpu_rdata = zero-extended byte lane 2 of word 0x104.
- Store byte 0xAB to 0x0000_0101 on a hit, then load word 0x100 → only bits [15:8] change, to 0xAB; no memory transaction.
- With line 0 dirty (tag 0), load 0x0000_0080 (same index, tag 1) → 4 writes to 0x000–0x00C carrying the dirty data, then 4 reads from 0x080–0x08C; stall lasts 18 cycles.
- Memory ack delayed 5 cycles per transaction → mem_addr and mem_req stay stable until ack; mem_req drops for one cycle between beats; final data is correct.
- Assert rst during the 2nd refill beat, release, then load the same address → full 4-beat refill restarts from word 0; stall=0 during reset.

Source files
------------

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back / write-allocate data cache with a handshaked
// backing-memory port; misses are serviced by a writeback/refill FSM.
module dcache_wb_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int SETS            = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_byte,
    input  logic                  cpu_wen,
    input  logic                  cpu_ren,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);
    localparam int WB = $clog2(WORDS_PER_BLOCK);
    localparam int CW = (WB > 0) ? WB : 1;
    localparam int IB = $clog2(SETS);
    localparam int TW = 32 - 2 - WB - IB;
    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [SETS-1:0]       valid;
    logic [SETS-1:0]       dirty;
    logic [TW-1:0]         tags [SETS];
    logic [DATA_WIDTH-1:0] data [SETS][WORDS_PER_BLOCK];

    logic [1:0]            off;
    logic [CW-1:0]         word;
    logic [IB-1:0]         idx;
    logic [TW-1:0]         tag;
    logic                  req, hit, store_hit, refill_beat, refill_last;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [31:0]           old_base, new_base, beat_off;

    assign off  = cpu_addr[1:0];
    assign word = cpu_addr[2 +: CW] & LAST;
    assign idx  = cpu_addr[2+WB +: IB];
    assign tag  = cpu_addr[31 -: TW];

    assign req     = cpu_ren | cpu_wen;
    assign hit     = valid[idx] & (tags[idx] == tag);
    assign rd_word = data[idx][word];

    // A store wins over a simultaneous load; stores only land from IDLE.
    assign store_hit   = ~rst & (state == IDLE) & cpu_wen & hit;
    assign refill_beat = ~rst & (state == REFILL) & mem_req & mem_ack;
    assign refill_last = refill_beat & (cnt == LAST);

    assign old_base = {tags[idx], idx, {(WB+2){1'b0}}};
    assign new_base = {tag, idx, {(WB+2){1'b0}}};
    assign beat_off = {{(30-CW){1'b0}}, cnt, 2'b00};

    assign stall = rst ? 1'b0 : ((state == IDLE) ? (req & ~hit) : 1'b1);

    always_comb begin
        cpu_rdata = '0;
        if (!rst && cpu_ren && !cpu_wen && hit) begin
            if (cpu_byte) cpu_rdata = {{(DATA_WIDTH-8){1'b0}}, rd_word[{off, 3'b000} +: 8]};
            else          cpu_rdata = rd_word;
        end
    end

    // Tag and data arrays carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (refill_beat) data[idx][cnt] <= mem_rdata;
        if (refill_last) tags[idx] <= tag;
        if (store_hit) begin
            if (cpu_byte) data[idx][word][{off, 3'b000} +: 8] <= cpu_wdata[7:0];
            else          data[idx][word] <= cpu_wdata;
        end
    end

    // Each beat: one cycle with mem_req low, then raise and hold until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            valid     <= '0;
            dirty     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (store_hit) dirty[idx] <= 1'b1;
                    if (req && !hit) begin
                        if (valid[idx] && dirty[idx]) begin
                            state <= WRITEBACK;
                        end else begin
                            state      <= REFILL;
                            valid[idx] <= 1'b0;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= old_base | beat_off;
                        mem_wdata <= data[idx][cnt];
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
                        if (cnt == LAST) begin
                            state      <= REFILL;
                            valid[idx] <= 1'b0;
                            dirty[idx] <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= new_base | beat_off;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
                        if (cnt == LAST) begin
                            state      <= DONE;
                            valid[idx] <= 1'b1;
                            dirty[idx] <= 1'b0;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Scoreboard bench for dcache_wb_ctrl: a responder models backing memory,
// a monitor checks memory transactions and load data against queued expectations.
module tb_dcache_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_byte = 1'b0;
    logic        cpu_wen = 1'b0;
    logic        cpu_ren = 1'b0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    dcache_wb_ctrl #(.DATA_WIDTH(32), .SETS(8), .WORDS_PER_BLOCK(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byte(cpu_byte),
        .cpu_wen(cpu_wen), .cpu_ren(cpu_ren), .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_txn[$];
    logic [31:0] exp_load[$];
    logic [31:0] mem_arr [256];
    int          ack_delay = 1;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_reads(input logic [31:0] base);
        for (int k = 0; k < 4; k++) exp_txn.push_back('{1'b0, base + 32'(4*k), 32'h0});
    endtask

    task automatic push_writes(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
        exp_txn.push_back('{1'b1, base,          w0});
        exp_txn.push_back('{1'b1, base + 32'h4,  w1});
        exp_txn.push_back('{1'b1, base + 32'h8,  w2});
        exp_txn.push_back('{1'b1, base + 32'hC,  w3});
    endtask

    // Called at posedge+1; holds the request until stall drops, counting stalled cycles.
    task automatic do_access(input string name, input logic [31:0] a, input logic [31:0] wd,
                             input logic b, input logic w, input logic r, input int exp_stall);
        int n;
        n = 0;
        cpu_addr = a; cpu_wdata = wd; cpu_byte = b; cpu_wen = w; cpu_ren = r;
        forever begin
            @(negedge clk); #1;
            if (!stall) break;
            n++;
            if (n > 500) break;
        end
        check({name, " stall"}, 32'(n), 32'(exp_stall));
        @(posedge clk); #1;
        cpu_wen = 1'b0; cpu_ren = 1'b0;
    endtask

    // Backing memory: acks after the request has been visible for ack_delay cycles.
    initial begin
        int age;
        age = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'hCAFE_0000 | 32'(i << 2);
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && !rst) begin
                age++;
                if (age >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
                    else        mem_rdata = mem_arr[mem_addr[9:2]];
                    @(posedge clk); #1;
                    mem_ack = 1'b0;
                    mem_rdata = '0;
                    age = 0;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: transaction scoreboard, handshake stability and load data.
    initial begin
        logic        prev_req, prev_ack;
        logic [31:0] held_addr;
        txn_t        t;
        prev_req = 1'b0; prev_ack = 1'b0; held_addr = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (prev_ack) check("req_gap", {31'b0, mem_req}, 32'h0);
                else if (prev_req && mem_req) check("addr_hold", mem_addr, held_addr);
                if (mem_req && !prev_req) held_addr = mem_addr;
                if (mem_req && mem_ack) begin
                    if (exp_txn.size() == 0) begin
                        check("txn_unexpected", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        t = exp_txn.pop_front();
                        check("txn_we", {31'b0, mem_we}, {31'b0, t.we});
                        check("txn_addr", mem_addr, t.addr);
                        if (t.we) check("txn_wdata", mem_wdata, t.wdata);
                    end
                end
                if (cpu_ren && !cpu_wen && !stall) begin
                    if (exp_load.size() == 0) check("load_unexpected", cpu_rdata, 32'hFFFF_FFFF);
                    else check("load_data", cpu_rdata, exp_load.pop_front());
                end
            end
            prev_req = mem_req & ~rst;
            prev_ack = mem_req & mem_ack & ~rst;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset with a load held: outputs must stay quiet.
        cpu_addr = 32'h100; cpu_ren = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst stall", {31'b0, stall}, 32'h0);
        check("rst rdata", cpu_rdata, 32'h0);
        check("rst mem_req", {31'b0, mem_req}, 32'h0);
        check("rst mem_we", {31'b0, mem_we}, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; cpu_ren = 1'b0;

        // Clean miss then hit.
        push_reads(32'h100);
        exp_load.push_back(32'hCAFE_0100);
        do_access("ld100", 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 10);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("idle stall", {31'b0, stall}, 32'h0);
            check("idle mem_req", {31'b0, mem_req}, 32'h0);
        end
        @(posedge clk); #1;

        exp_load.push_back(32'h0000_00FE);
        do_access("ldb106", 32'h106, 32'h0, 1'b1, 1'b0, 1'b1, 0);

        do_access("stb101", 32'h101, 32'h0000_00AB, 1'b1, 1'b1, 1'b0, 0);
        exp_load.push_back(32'hCAFE_AB00);
        do_access("ld100b", 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 0);

        // Dirty line 0 (tag 2) evicted by tag 0.
        push_writes(32'h100, 32'hCAFE_AB00, 32'hCAFE_0104, 32'hCAFE_0108, 32'hCAFE_010C);
        push_reads(32'h000);
        exp_load.push_back(32'hCAFE_0000);
        do_access("ld000", 32'h000, 32'h0, 1'b0, 1'b0, 1'b1, 18);

        do_access("stw008", 32'h00A, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 0);

        // Dirty line 0 (tag 0) evicted by 0x080 (tag 1).
        push_writes(32'h000, 32'hCAFE_0000, 32'hCAFE_0004, 32'h1234_5678, 32'hCAFE_000C);
        push_reads(32'h080);
        exp_load.push_back(32'hCAFE_0080);
        do_access("ld080", 32'h080, 32'h0, 1'b0, 1'b0, 1'b1, 18);

        // Slow memory: 6 cycles per beat, refetches the written-back store.
        ack_delay = 5;
        push_reads(32'h000);
        exp_load.push_back(32'h1234_5678);
        do_access("ld008slow", 32'h008, 32'h0, 1'b0, 1'b0, 1'b1, 26);
        ack_delay = 1;

        push_reads(32'h100);
        exp_load.push_back(32'h0000_00AB);
        do_access("ldb101", 32'h101, 32'h0, 1'b1, 1'b0, 1'b1, 10);

        // Reset during the second refill beat.
        exp_txn.push_back('{1'b0, 32'h200, 32'h0});
        cpu_addr = 32'h208; cpu_ren = 1'b1; cpu_byte = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("beat1 req", {31'b0, mem_req}, 32'h1);
        check("beat1 addr", mem_addr, 32'h204);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst stall", {31'b0, stall}, 32'h0);
        check("midrst rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("midrst mem_req", {31'b0, mem_req}, 32'h0);
        @(posedge clk); #1;
        cpu_ren = 1'b0; rst = 1'b0;

        push_reads(32'h200);
        exp_load.push_back(32'hCAFE_0208);
        do_access("ld208", 32'h208, 32'h0, 1'b0, 1'b0, 1'b1, 10);

        repeat (3) @(posedge clk);
        #1;
        check("txn_left", 32'(exp_txn.size()), 32'h0);
        check("load_left", 32'(exp_load.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
